// File: rtl/mf_disp_ahb_wr_bridge.sv
// ---------------------------------------------------------------------------
// mf_disp_ahb_wr_bridge
//
// Purpose:
//   AHB-Lite slave for the display aperture. Each AHB write becomes a
//   single-beat sys_wr_* transaction toward the display controller. Writes
//   sit in a small FIFO, so the CPU stalls only when that buffer is full.
//   Misaligned writes and writes of an unsupported size get a two-cycle
//   ERROR response and are counted. Reads always complete with zero data.
//
// Ports:
//   sys_clk, resetn        clock; synchronous active-low reset
//   HSEL/HADDR/HTRANS/
//   HWRITE/HSIZE/HWDATA/
//   HREADY                 AHB-Lite slave inputs (only HADDR[17:0] used)
//   HREADYOUT/HRESP/HRDATA AHB-Lite slave outputs (HRDATA is always 0)
//   sys_wr_rdy             downstream accept
//   sys_wr_vld/addr/
//   strb/data              FIFO head (word address, byte lanes, data)
//   err_cnt                saturating count of dropped illegal writes
//   fifo_lvl               current FIFO occupancy
// ---------------------------------------------------------------------------
module mf_disp_ahb_wr_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                          sys_clk,
    input  logic                          resetn,
    input  logic                          HSEL,
    input  logic [31:0]                   HADDR,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [31:0]                   HWDATA,
    input  logic                          HREADY,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [31:0]                   HRDATA,
    input  logic                          sys_wr_rdy,
    output logic                          sys_wr_vld,
    output logic [15:0]                   sys_wr_addr,
    output logic [3:0]                    sys_wr_strb,
    output logic [31:0]                   sys_wr_data,
    output logic [ERR_CNT_W-1:0]          err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 16 + 4 + 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_t;

    // Size/alignment legality of an AHB write.
    function automatic logic size_legal(input logic [2:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (lo[0] == 1'b0);
            3'd2:    ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables for a legal write.
    function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            3'd0:    s = 4'b0001 << lo;
            3'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    state_t                 state_q, state_d;
    logic [15:0]            waddr_q, waddr_d;
    logic [3:0]             strb_q, strb_d;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];

    logic                   accept_s;
    logic                   decode_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   hreadyout_s;
    logic                   hresp_s;
    logic                   err_inc_s;
    logic [PTR_W:0]         level_s;
    logic [ENT_W-1:0]       head_s;
    logic                   unused_bits_s;

    assign unused_bits_s = ^{HADDR[31:18], HTRANS[0]};

    assign accept_s = HSEL & HREADY & HTRANS[1];
    assign level_s  = wr_ptr_q - rd_ptr_q;
    // Full is judged on the registered level only, so sys_wr_rdy never
    // reaches HREADYOUT combinationally.
    assign full_s   = (level_s == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign pop_s    = ~empty_s & sys_wr_rdy;
    assign head_s   = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next-state, bus response and push decode.
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        strb_d      = strb_q;
        push_s      = 1'b0;
        decode_s    = 1'b0;
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
        err_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                decode_s = 1'b1;
            end
            ST_WDATA: begin
                if (full_s) begin
                    hreadyout_s = 1'b0;
                end else begin
                    push_s   = 1'b1;
                    decode_s = 1'b1;
                end
            end
            ST_ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = 1'b1;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_s   = 1'b1;
                err_inc_s = 1'b1;
                decode_s  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address phase is only looked at while this slave is ready.
        if (decode_s) begin
            if (accept_s && HWRITE) begin
                if (size_legal(HSIZE, HADDR[1:0])) begin
                    state_d = ST_WDATA;
                    waddr_d = HADDR[17:2];
                    strb_d  = lane_strb(HSIZE, HADDR[1:0]);
                end else begin
                    state_d = ST_ERR1;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_d;
        end
    end

    // Pointer and error counter next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{PTR_W{1'b0}}, push_s};
        rd_ptr_d  = rd_ptr_q + {{PTR_W{1'b0}}, pop_s};
        err_cnt_d = err_cnt_q;
        if (err_inc_s && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            waddr_q   <= 16'h0000;
            strb_q    <= 4'b0000;
            wr_ptr_q  <= {(PTR_W+1){1'b0}};
            rd_ptr_q  <= {(PTR_W+1){1'b0}};
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            strb_q    <= strb_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // FIFO storage; contents are irrelevant while empty, outputs are gated.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {waddr_q, strb_q, HWDATA};
        end
    end

    assign HREADYOUT   = hreadyout_s;
    assign HRESP       = hresp_s;
    assign HRDATA      = 32'h0000_0000;
    assign sys_wr_vld  = ~empty_s;
    assign sys_wr_addr = empty_s ? 16'h0000       : head_s[51:36];
    assign sys_wr_strb = empty_s ? 4'b0000        : head_s[35:32];
    assign sys_wr_data = empty_s ? 32'h0000_0000  : head_s[31:0];
    assign err_cnt     = err_cnt_q;
    assign fifo_lvl    = level_s;

endmodule

// File: tb/tb_mf_disp_ahb_wr_bridge.sv
// Scoreboard bench: expected sys_wr beats are queued when the address phase
// is accepted; a monitor thread pops and compares on every sys_wr handshake.
module tb_mf_disp_ahb_wr_bridge;

    logic        sys_clk;
    logic        resetn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        sys_wr_rdy;
    logic        sys_wr_vld;
    logic [15:0] sys_wr_addr;
    logic [3:0]  sys_wr_strb;
    logic [31:0] sys_wr_data;
    logic [7:0]  err_cnt;
    logic [2:0]  fifo_lvl;

    assign HREADY = HREADYOUT;

    mf_disp_ahb_wr_bridge #(.FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
        .sys_clk(sys_clk), .resetn(resetn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .sys_wr_rdy(sys_wr_rdy), .sys_wr_vld(sys_wr_vld), .sys_wr_addr(sys_wr_addr),
        .sys_wr_strb(sys_wr_strb), .sys_wr_data(sys_wr_data), .err_cnt(err_cnt),
        .fifo_lvl(fifo_lvl)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_err  = 0;
    int          stall_cnt;
    int          max_lvl;
    bit          rnd_done;
    logic [51:0] sb [$];

    logic [31:0] t_addr  [512];
    logic [2:0]  t_size  [512];
    logic        t_write [512];
    logic [31:0] t_data  [512];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic bit m_legal(input logic [2:0] sz, input int unsigned a);
        return (sz == 3'd0) || (sz == 3'd1 && a % 2 == 0) || (sz == 3'd2 && a % 4 == 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] sz, input int unsigned a);
        int unsigned v;
        if (sz == 3'd0)      v = 1 << (a % 4);
        else if (sz == 3'd1) v = 3 << (a % 4);
        else                 v = 15;
        return v[3:0];
    endfunction

    task automatic set_tr(input int i, input logic [31:0] a, input logic [2:0] sz,
                          input logic w, input logic [31:0] d);
        t_addr[i] = a; t_size[i] = sz; t_write[i] = w; t_data[i] = d;
    endtask

    // Reference behaviour at the moment an address phase is accepted.
    task automatic model_accept(input int i);
        int unsigned a;
        a = t_addr[i];
        if (t_write[i]) begin
            if (m_legal(t_size[i], a)) sb.push_back({t_addr[i][17:2], m_strb(t_size[i], a), t_data[i]});
            else if (exp_err < 255) exp_err++;
        end
    endtask

    // Pipelined AHB master: address of i overlaps data phase of i-1.
    task automatic run_burst(input int n);
        int ai, di, errc, budget;
        bit rdy;
        ai = 0; di = -1; errc = 0; budget = 0;
        while ((ai < n || di >= 0) && budget < 20000) begin
            if (ai < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HADDR = t_addr[ai];
                HSIZE = t_size[ai]; HWRITE = t_write[ai];
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
            end
            HWDATA = (di >= 0) ? t_data[di] : 32'h0;
            @(negedge sys_clk);
            rdy = HREADYOUT;
            if (!rdy) stall_cnt++;
            if (di >= 0) begin
                if (t_write[di] && !m_legal(t_size[di], t_addr[di])) begin
                    check("err_hresp", HRESP, 1'b1);
                    check("err_hreadyout", HREADYOUT, (errc == 1) ? 1'b1 : 1'b0);
                    errc++;
                end else begin
                    check("okay_hresp", HRESP, 1'b0);
                    if (!t_write[di]) check("hrdata", HRDATA, 32'h0);
                end
            end
            @(posedge sys_clk); #1;
            budget++;
            if (rdy) begin
                errc = 0;
                if (ai < n) begin
                    model_accept(ai);
                    di = ai;
                    ai++;
                end else begin
                    di = -1;
                end
            end
        end
        check("burst_complete", (ai >= n && di < 0) ? 1'b1 : 1'b0, 1'b1);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic drain();
        int k;
        sys_wr_rdy = 1'b1;
        k = 0;
        while ((sb.size() != 0 || fifo_lvl != 3'd0) && k < 100) begin
            @(posedge sys_clk); #1;
            k++;
        end
        check("drain_lvl", fifo_lvl, 3'd0);
        check("drain_sb_empty", sb.size(), 0);
    endtask

    initial begin
        logic [51:0] e;
        resetn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd0; HWDATA = 32'h0; sys_wr_rdy = 1'b1;
        stall_cnt = 0; max_lvl = 0; rnd_done = 1'b0;

        // Monitor: compare every sys_wr handshake against the scoreboard.
        fork
            forever begin
                @(negedge sys_clk);
                if (int'(fifo_lvl) > max_lvl) max_lvl = int'(fifo_lvl);
                if (resetn && sys_wr_vld && sys_wr_rdy) begin
                    if (sb.size() == 0) check("unexpected_wr", sys_wr_vld, 1'b0);
                    else begin
                        e = sb.pop_front();
                        check("wr_beat", {sys_wr_addr, sys_wr_strb, sys_wr_data}, e);
                    end
                end
            end
        join_none

        repeat (2) @(posedge sys_clk);
        #1 resetn = 1'b1;
        check("rst_hreadyout", HREADYOUT, 1'b1);
        check("rst_hresp", HRESP, 1'b0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_vld", sys_wr_vld, 1'b0);
        check("rst_wr_fields", {sys_wr_addr, sys_wr_strb, sys_wr_data}, 52'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        check("rst_lvl", fifo_lvl, 3'd0);

        // Single word write with one-cycle latency to sys_wr_vld.
        set_tr(0, 32'h0000_1234, 3'd2, 1'b1, 32'hDEAD_BEEF);
        run_burst(1);
        check("word_latency_vld", sys_wr_vld, 1'b1);
        check("word_addr", sys_wr_addr, 16'h048D);
        drain();

        // Back-to-back bytes on all four lanes.
        for (int i = 0; i < 4; i++) set_tr(i, 32'h0000_0100 + i, 3'd0, 1'b1, $urandom);
        stall_cnt = 0; max_lvl = 0;
        run_burst(4);
        drain();
        check("bytes_no_stall", stall_cnt, 0);
        check("bytes_max_lvl_le1", (max_lvl <= 1) ? 1'b1 : 1'b0, 1'b1);

        // Six words against a stalled sink.
        sys_wr_rdy = 1'b0;
        for (int i = 0; i < 6; i++) set_tr(i, 32'h0000_2000 + 4 * i, 3'd2, 1'b1, $urandom);
        fork
            run_burst(6);
            begin
                repeat (8) @(posedge sys_clk);
                @(negedge sys_clk);
                check("full_hreadyout", HREADYOUT, 1'b0);
                check("full_lvl", fifo_lvl, 3'd4);
                @(posedge sys_clk); #1 sys_wr_rdy = 1'b1;
                @(negedge sys_clk);
                check("first_pop_still_stalled", HREADYOUT, 1'b0);
                @(negedge sys_clk);
                check("after_pop_ready", HREADYOUT, 1'b1);
                check("after_pop_lvl", fifo_lvl, 3'd3);
            end
        join
        drain();

        // Misaligned halfword then a legal word.
        set_tr(0, 32'h0000_0201, 3'd1, 1'b1, 32'h1111_2222);
        set_tr(1, 32'h0000_0204, 3'd2, 1'b1, 32'h3333_4444);
        run_burst(2);
        drain();
        check("err_cnt_one", err_cnt, exp_err);

        // Randomised mix of reads/writes, sizes and sink back-pressure.
        for (int i = 0; i < 200; i++)
            set_tr(i, $urandom, 3'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), $urandom);
        rnd_done = 1'b0;
        fork
            begin run_burst(200); rnd_done = 1'b1; end
            begin
                while (!rnd_done) begin
                    @(posedge sys_clk); #1 sys_wr_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        check("rand_err_cnt", err_cnt, exp_err);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) set_tr(i, 32'h0000_0000, 3'd3, 1'b1, $urandom);
        run_burst(300);
        drain();
        check("err_cnt_sat", err_cnt, exp_err);

        // Reset discards queued writes.
        sys_wr_rdy = 1'b0;
        for (int i = 0; i < 3; i++) set_tr(i, 32'h0000_3000 + 4 * i, 3'd2, 1'b1, $urandom);
        run_burst(3);
        check("pre_rst_lvl", fifo_lvl, 3'd3);
        resetn = 1'b0;
        @(posedge sys_clk); #1 resetn = 1'b1;
        sb.delete();
        exp_err = 0;
        check("rst2_lvl", fifo_lvl, 3'd0);
        check("rst2_vld", sys_wr_vld, 1'b0);
        check("rst2_err_cnt", err_cnt, 8'h0);
        check("rst2_hreadyout", HREADYOUT, 1'b1);
        sys_wr_rdy = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1 check("rst2_no_issue", sys_wr_vld, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mf_disp_ahb_wr_bridge.md
Name: mf_disp_ahb_wr_bridge

Overview:
AHB-Lite slave that terminates MIPSfpga bus writes to the display aperture. It converts each write into a single-beat sys_wr_vld/addr/strb/data transaction, which is the write port of the display controller top. Writes are buffered in a small FIFO so the CPU is stalled only when the buffer is full. Misaligned or unsupported-size writes get a two-cycle AHB ERROR response. Reads complete with zero data.

Parameters:
FIFO_DEPTH, 4, write-buffer entries; power of two, minimum 2.
ERR_CNT_W, 8, width of the saturating dropped-write counter.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
resetn  in  1  synchronous, active-low reset.
HSEL  in  1  slave select.
HADDR  in  32  AHB address; only [17:0] used.
HTRANS  in  2  transfer type; bit1 set means NONSEQ/SEQ.
HWRITE  in  1  1 = write.
HSIZE  in  3  0 = byte, 1 = half, 2 = word, others are illegal.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-wide ready.
HREADYOUT  out  1  slave ready.
HRESP  out  1  1 = ERROR.
HRDATA  out  32  always 0.
sys_wr_rdy  in  1  downstream accept; tied 1'b1 at the current display top.
sys_wr_vld  out  1  FIFO head valid.
sys_wr_addr  out  16  word address, equal to HADDR[17:2].
sys_wr_strb  out  4  byte lane enables.
sys_wr_data  out  32  write data.
err_cnt  out  ERR_CNT_W  count of dropped illegal writes, saturating.
fifo_lvl  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - FSM goes to IDLE; FIFO is emptied and any pending writes are discarded.
  - HREADYOUT=1, HRESP=0, HRDATA=0, sys_wr_vld=0, sys_wr_addr/strb/data=0, err_cnt=0, fifo_lvl=0.
- Address-phase accept: HSEL & HREADY & HTRANS[1]. The bridge latches HADDR[17:0], HSIZE and HWRITE.
- Legality check on a write:
  - HSIZE=0: always legal.
  - HSIZE=1: legal only if HADDR[0]=0.
  - HSIZE=2: legal only if HADDR[1:0]=0.
  - HSIZE>2: illegal.
- Strobe generation:
  - byte: 4'b0001 << HADDR[1:0].
  - half: HADDR[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- HWDATA is passed through unshifted. The AHB master has already placed data on the correct byte lanes.
- FSM states: IDLE, WDATA, ERR1, ERR2.
  - IDLE: on a legal write accept go to WDATA; on an illegal write go to ERR1; on a read or idle transfer stay in IDLE (zero-wait OKAY).
  - WDATA: HREADYOUT = ~full.
    - While full: hold in WDATA and ignore the address bus (HREADY is low).
    - When not full: push {addr, strb, HWDATA} this cycle, then take the next state from the concurrent address phase, with the same rules as IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, no push, address bus ignored. Next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. err_cnt increments, saturating at all-ones. Next state is decoded from the concurrent address phase, with the same rules as IDLE.
- full means fifo_lvl == FIFO_DEPTH at the start of the cycle. A pop in the same cycle does not relieve the stall; this avoids a combinational path from sys_wr_rdy to HREADYOUT.
- FIFO:
  - Push and pop in the same cycle are allowed when neither full nor empty; the level is then unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH; the extra MSB distinguishes full from empty.
- Output side:
  - sys_wr_vld = ~empty; sys_wr_* present the head entry.
  - Pop when sys_wr_vld & sys_wr_rdy.
  - The head is held stable while sys_wr_rdy=0.
- Latency: a push at edge N (data-phase cycle with HREADYOUT=1) produces sys_wr_vld=1 in the cycle after edge N, given an empty FIFO.
- Ordering: entries issue in bus order. Throughput is one write per cycle sustained when sys_wr_rdy=1.
- Reads: always zero-wait OKAY with HRDATA=0, including while writes are pending in the FIFO (no read-after-write ordering is provided).

Test Plan:
- Word write to HADDR=0x0000_1234 (HSIZE=2, HADDR[1:0]=0), HWDATA=0xDEADBEEF, sys_wr_rdy=1 -> one sys_wr_vld pulse the cycle after the data phase, with addr=0x048D, strb=4'b1111, data=0xDEADBEEF; HRESP=0.
- Byte writes to HADDR[1:0]=0,1,2,3 back-to-back -> strb sequence 0001, 0010, 0100, 1000 in order; HREADYOUT stays 1; fifo_lvl never exceeds 1.
- sys_wr_rdy=0 with 6 consecutive word writes (FIFO_DEPTH=4):
  - First 4 complete with no wait; the 5th data phase sees HREADYOUT=0 and fifo_lvl=4.
  - Raise sys_wr_rdy -> the 5th completes one cycle after the first pop, then the 6th.
  - All 6 emerge in order with correct data.
- Halfword write to HADDR=...1 followed by a word write -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); err_cnt becomes 1; no sys_wr_vld for the bad write; the following legal write is accepted.
- HSIZE=3 write 300 times -> err_cnt saturates at 255.
- 3 entries queued with sys_wr_rdy=0, then resetn=0 for one edge -> fifo_lvl=0, sys_wr_vld=0, err_cnt=0; the entries are never issued after reset releases.
